mult32_seq: RTL and testbench

Sequential shift-add multiplier controller and datapath. It computes a 2·WIDTH-bit product, signed or unsigned, by time-sharing a single WIDTH-bit ripple adder (RC_ADD_SUB_32) over WIDTH iterations. It sits beside the ALU and serves the MUL instruction path. The controller accepts one operation at a time and holds the product until the next accepted start.

---
 rtl/mult_pkg.sv | 12 +
 rtl/mult32_dp.sv | 63 ++++++
 rtl/mult32_seq.sv | 74 +++++++
 tb/tb_mult32_seq.sv | 113 +++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// mult_pkg: shared FSM state encoding, default operand width and counter width for the sequential multiplier
package mult_pkg;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;
  localparam int DEF_WIDTH = 32;
  localparam int CNT_W = $clog2(DEF_WIDTH);
endpackage

// File: rtl/mult32_dp.sv
// mult32_dp: operand/M/HI/LO registers, ripple adder, magnitude and 2W-bit negate, shifter; cap/load/iter/fix strobes in, hi/lo out
module mult32_dp
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cap,
  input  logic             load,
  input  logic             iter,
  input  logic             fix,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, m_q, m_d, hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] addend, a_mag, b_mag;
  logic [WIDTH:0] sum_c;
  logic [2*WIDTH-1:0] neg;
  always_comb begin : ripple
    logic c;
    c = 1'b0;
    sum_c = '0;
    addend = lo_q[0] ? m_q : '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum_c[i] = hi_q[i] ^ addend[i] ^ c;
      c = (hi_q[i] & addend[i]) | (c & (hi_q[i] ^ addend[i]));
    end
    sum_c[WIDTH] = c;
  end
  always_comb begin
    a_mag = (op_signed && a_q[WIDTH-1]) ? -a_q : a_q;
    b_mag = (op_signed && b_q[WIDTH-1]) ? -b_q : b_q;
    neg = -{hi_q, lo_q};
    a_d = cap ? a : a_q;
    b_d = cap ? b : b_q;
    m_d = load ? a_mag : m_q;
    // The carry-out re-enters HI's MSB as the pair shifts right.
    {hi_d, lo_d} = load ? {{WIDTH{1'b0}}, b_mag} :
                   iter ? {sum_c, lo_q[WIDTH-1:1]} :
                   fix  ? neg : {hi_q, lo_q};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      m_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      m_q <= m_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end
  assign hi = hi_q;
  assign lo = lo_q;
endmodule

// File: rtl/mult32_seq.sv
// mult32_seq: shift-add multiplier FSM; START/OP_SIGNED/A/B in, BUSY/DONE and registered HI/LO product out
module mult32_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic             OP_SIGNED,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);
  localparam int CW = $clog2(WIDTH);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic op_q, op_d, sign_q, sign_d, busy_q, busy_d, done_q, done_d;
  logic accept, load, iter, fix;
  always_comb begin
    accept = START && (state_q == S_IDLE || state_q == S_DONE);
    load = state_q == S_PREP;
    iter = state_q == S_ITER;
    fix = state_q == S_FIX && sign_q;
    op_d = accept ? OP_SIGNED : op_q;
    sign_d = accept ? OP_SIGNED & (A[WIDTH-1] ^ B[WIDTH-1]) : sign_q;
    cnt_d = load ? '0 : iter ? CW'(cnt_q + 1) : cnt_q;
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: state_d = START ? S_PREP : S_IDLE;
      S_PREP:         state_d = S_ITER;
      S_ITER:         state_d = cnt_q == CW'(WIDTH - 1) ? S_FIX : S_ITER;
      S_FIX:          state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
    busy_d = state_d inside {S_PREP, S_ITER, S_FIX};
    done_d = state_d == S_DONE;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      op_q <= 1'b0;
      sign_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      op_q <= op_d;
      sign_q <= sign_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  mult32_dp #(.WIDTH(WIDTH)) u_dp (
    .clk(CLK),
    .rst(RESET),
    .cap(accept),
    .load(load),
    .iter(iter),
    .fix(fix),
    .op_signed(op_q),
    .a(A),
    .b(B),
    .hi(HI),
    .lo(LO)
  );
  assign BUSY = busy_q;
  assign DONE = done_q;
endmodule

// File: tb/tb_mult32_seq.sv
// tb_mult32_seq: directed-vector self-checking bench for mult32_seq
module tb_mult32_seq;
  logic clk = 1'b0, rst, start, op;
  logic [31:0] a, b, hi, lo;
  logic busy, done;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  mult32_seq dut (
    .CLK(clk),
    .RESET(rst),
    .START(start),
    .OP_SIGNED(op),
    .A(a),
    .B(b),
    .BUSY(busy),
    .DONE(done),
    .HI(hi),
    .LO(lo)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic s,
                        input logic [31:0] ehi, input logic [31:0] elo, input int inj);
    start = 1'b1;
    a = ia;
    b = ib;
    op = s;
    for (int c = 1; c <= 35; c++) begin
      tick();
      start = c == inj;
      op = 1'b0;
      a = c == inj ? 32'h7 : 'x;
      b = c == inj ? 32'h6 : 'x;
      check($sformatf("busy@%0d", c), busy, c <= 34);
      check($sformatf("done@%0d", c), done, c == 35);
    end
    check($sformatf("hi %h*%h s%0d", ia, ib, s), hi, ehi);
    check($sformatf("lo %h*%h s%0d", ia, ib, s), lo, elo);
  endtask
  initial begin
    rst = 1'b1;
    start = 1'b0;
    op = 1'b0;
    a = '0;
    b = '0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    rst = 1'b0;
    tick();
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001, 0);
    tick();
    check("done_drop", done, 0);
    check("hold_hi", hi, 32'hFFFFFFFE);
    check("hold_lo", lo, 32'h00000001);
    run_op(32'hFFFFFFFD, 32'h5, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1, 0);
    tick();
    run_op(32'hFFFFFFFD, 32'h5, 1'b0, 32'h00000004, 32'hFFFFFFF1, 10);
    tick();
    run_op(32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h0, 0);
    tick();
    run_op(32'h0, 32'hFFFFFFF9, 1'b1, 32'h0, 32'h0, 0);
    tick();
    run_op(32'hFFFFFFFD, 32'h5, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1, 0);
    run_op(32'h7, 32'h6, 1'b0, 32'h0, 32'h2A, 0);
    tick();
    start = 1'b1;
    a = 32'hFFFFFFFF;
    b = 32'hFFFFFFFF;
    op = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      tick();
      start = 1'b0;
      rst = c == 20;
    end
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    rst = 1'b0;
    tick();
    run_op(32'h7, 32'h6, 1'b0, 32'h0, 32'h2A, 0);
    tick();
    rst = 1'b1;
    start = 1'b1;
    a = 32'h5;
    b = 32'h5;
    tick();
    check("rs_busy", busy, 0);
    check("rs_done", done, 0);
    check("rs_hi", hi, 0);
    check("rs_lo", lo, 0);
    rst = 1'b0;
    start = 1'b0;
    tick();
    check("rs_idle_busy", busy, 0);
    check("rs_idle_hi", hi, 0);
    check("rs_idle_lo", lo, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
